// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared RV32I decode types: ALU/control-unit op codes, the
//               decoded bundle, opcode and funct7 constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU_ADD must stay at zero so a reset bundle reads as an add.
    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASSB,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } aluCode_t;

    typedef enum logic [3:0] {
        CU_NOP, CU_LUI, CU_AUIPC, CU_JAL, CU_JALR, CU_BRANCH, CU_LOAD, CU_STORE,
        CU_IMM, CU_REG, CU_ERROR
    } cuOPType;

    typedef struct packed {
        cuOPType          cuOP;
        aluCode_t         aluOP;
        logic             regWrite;
        logic             memWrite;
        logic             memRead;
        logic             aluSrc;
        logic             branch;
        logic             sign;
        logic [XLEN-1:0]  imm;
        logic [4:0]       reg1;
        logic [4:0]       reg2;
        logic [4:0]       regd;
        logic [XLEN-1:0]  pc;
        logic             illegal;
    } dec_t;

    // Base-ISA ALU op for the OP/OP-IMM funct3 field (funct7 variants handled by caller).
    function automatic aluCode_t alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
// ============================================================================
// Module      : decode_stage_if
// Description : Fetch-side and execute-side handshake bundle of decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_stage_if
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    dec_t            out_dec;
    logic [CW-1:0]   occupancy;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_dec, occupancy
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_dec, occupancy
    );

endinterface

`default_nettype wire

// File: rtl/control_decoder.sv
// ============================================================================
// Module      : control_decoder
// Description : Combinational RV32I instruction -> dec_t decoder.
//               Build macro RV32M_EN enables the M-extension encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decoder
    import cpu_pkg::*;
(
    input  wire logic [31:0]     instr,
    input  wire logic [XLEN-1:0] pc,
    output dec_t                 dec
);

    logic [6:0]      w_op;
    logic [6:0]      w_f7;
    logic [2:0]      w_f3;
    logic            w_legal;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_op = instr[6:0];
    assign w_f3 = instr[14:12];
    assign w_f7 = instr[31:25];

    assign w_imm_i = XLEN'($signed(instr[31:20]));
    assign w_imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign w_imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    always_comb begin
        dec        = '0;
        dec.cuOP   = CU_ERROR;
        dec.aluOP  = ALU_ADD;
        dec.sign   = 1'b1;
        dec.reg1   = instr[19:15];
        dec.reg2   = instr[24:20];
        dec.regd   = instr[11:7];
        dec.pc     = pc;
        w_legal    = 1'b1;

        case (w_op)
            OP_LUI: begin
                dec.cuOP = CU_LUI; dec.aluOP = ALU_PASSB; dec.imm = w_imm_u;
                dec.aluSrc = 1'b1; dec.regWrite = 1'b1;
            end
            OP_AUIPC: begin
                dec.cuOP = CU_AUIPC; dec.imm = w_imm_u;
                dec.aluSrc = 1'b1; dec.regWrite = 1'b1;
            end
            OP_JAL: begin
                dec.cuOP = CU_JAL; dec.imm = w_imm_j; dec.regWrite = 1'b1;
            end
            OP_JALR: begin
                dec.cuOP = CU_JALR; dec.imm = w_imm_i;
                dec.aluSrc = 1'b1; dec.regWrite = 1'b1;
                w_legal = (w_f3 == 3'd0);
            end
            OP_BRANCH: begin
                dec.cuOP   = CU_BRANCH;
                dec.imm    = w_imm_b;
                dec.branch = 1'b1;
                dec.sign   = !w_f3[1];
                case (w_f3[2:1])
                    2'b00:   dec.aluOP = ALU_SUB;
                    2'b10:   dec.aluOP = ALU_SLT;
                    2'b11:   dec.aluOP = ALU_SLTU;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec.cuOP = CU_LOAD; dec.imm = w_imm_i;
                dec.aluSrc = 1'b1; dec.memRead = 1'b1; dec.regWrite = 1'b1;
                dec.sign = !w_f3[2];
                w_legal  = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
            end
            OP_STORE: begin
                dec.cuOP = CU_STORE; dec.imm = w_imm_s;
                dec.aluSrc = 1'b1; dec.memWrite = 1'b1;
                w_legal = (w_f3 <= 3'd2);
            end
            OP_IMM: begin
                dec.cuOP = CU_IMM; dec.imm = w_imm_i;
                dec.aluSrc = 1'b1; dec.regWrite = 1'b1;
                dec.aluOP = alu_from_f3(w_f3);
                dec.sign  = (w_f3 != 3'd3);
                // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
                if (w_f3 == 3'd1) begin
                    w_legal = (w_f7 == F7_BASE);
                end else if (w_f3 == 3'd5) begin
                    w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    if (w_f7 == F7_ALT) dec.aluOP = ALU_SRA;
                end
            end
            OP_REG: begin
                dec.cuOP = CU_REG; dec.regWrite = 1'b1;
                case (w_f7)
                    F7_BASE: begin
                        dec.aluOP = alu_from_f3(w_f3);
                        dec.sign  = (w_f3 != 3'd3);
                    end
                    F7_ALT: begin
                        if (w_f3 == 3'd0)      dec.aluOP = ALU_SUB;
                        else if (w_f3 == 3'd5) dec.aluOP = ALU_SRA;
                        else                   w_legal = 1'b0;
                    end
                    F7_MULDIV: begin
`ifdef RV32M_EN
                        dec.aluOP = aluCode_t'(ALU_MUL + {2'b00, w_f3});
`else
                        w_legal = 1'b0;
`endif
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            // FENCE/SYSTEM and everything else are left for execute to trap on.
            default: w_legal = 1'b0;
        endcase

        if (dec.regd == 5'd0) dec.regWrite = 1'b0;

        if (!w_legal) begin
            dec.illegal  = 1'b1;
            dec.cuOP     = CU_ERROR;
            dec.regWrite = 1'b0;
            dec.memWrite = 1'b0;
            dec.memRead  = 1'b0;
            dec.branch   = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I decode stage: decodes on accept and queues
//               bundles in a DEPTH-entry FIFO toward execute, with flush.
//               Build macro RV32M_EN (see control_decoder) enables RV32M.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input wire logic       clk,
    input wire logic       rst,
    decode_stage_if.slave  bus
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

    dec_t          r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    dec_t          w_dec;
    logic          w_push;
    logic          w_pop;

    control_decoder u_decoder (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .dec   (w_dec)
    );

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign bus.in_ready  = !rst && ((r_count < C_DEPTH) || bus.out_ready);
    assign bus.out_valid = (r_count != '0);
    assign bus.out_dec   = r_mem[r_rptr];
    assign bus.occupancy = r_count;

    assign w_push = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_dec;
                r_wptr        <= (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage (build with or without RV32M_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    localparam logic [31:0] I_ADDI = 32'h00510093;
    localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_ZERO = 32'h00000000;

    typedef struct {
        dec_t d;
        bit   partial;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.DEPTH(DEPTH)) bus ();

    decode_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mcnt     = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input cuOPType cu, input aluCode_t alu,
                                input bit rw, input bit mw, input bit mr, input bit src,
                                input bit br, input bit sg, input logic [31:0] imm,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic [31:0] pc, input bit ill, input bit partial);
        exp_t e;
        e.d.cuOP = cu;  e.d.aluOP = alu;
        e.d.regWrite = rw; e.d.memWrite = mw; e.d.memRead = mr;
        e.d.aluSrc = src; e.d.branch = br; e.d.sign = sg;
        e.d.imm = imm; e.d.reg1 = r1; e.d.reg2 = r2; e.d.regd = rd;
        e.d.pc = pc; e.d.illegal = ill;
        e.partial = partial;
        return e;
    endfunction

    function automatic exp_t addi_exp(input logic [31:0] pc);
        return mk(CU_IMM, ALU_ADD, 1, 0, 0, 1, 0, 1, 32'd5, 5'd2, 5'd5, 5'd1, pc, 0, 0);
    endfunction

    // Illegal bundles only pin the trap-relevant fields.
    function automatic exp_t illegal_exp(input logic [31:0] pc);
        return mk(CU_ERROR, ALU_ADD, 0, 0, 0, 0, 0, 0, 32'd0, 5'd0, 5'd0, 5'd0, pc, 1, 1);
    endfunction

    function automatic logic [9:0] key_fields(input dec_t d);
        return {d.illegal, 1'b0, d.cuOP, d.regWrite, d.memWrite, d.memRead, d.branch};
    endfunction

    // One cycle: drive at negedge, check state and scoreboard head, advance model.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit fl, input exp_t e);
        bit   exp_ready, push, pop;
        exp_t h;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        exp_ready = (mcnt < DEPTH) || ordy;
        check_eq("out_valid", 128'(bus.out_valid), 128'(mcnt != 0));
        check_eq("occupancy", 128'(bus.occupancy), 128'(mcnt));
        check_eq("in_ready", 128'(bus.in_ready), 128'(exp_ready));
        push = v && exp_ready && !fl;
        pop  = (mcnt != 0) && ordy && !fl;
        if (pop) begin
            h = sb.pop_front();
            if (h.partial)
                check_eq("out_dec_illegal", 128'(key_fields(bus.out_dec)), 128'(key_fields(h.d)));
            else
                check_eq("out_dec", 128'(bus.out_dec), 128'(h.d));
        end
        if (fl) begin
            sb.delete();
            mcnt = 0;
        end else begin
            if (push) sb.push_back(e);
            mcnt = mcnt + int'(push) - int'(pop);
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, I_ZERO, 32'h0, ordy, 1'b0, illegal_exp(32'h0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        #1;
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_occupancy", 128'(bus.occupancy), 128'(0));
        check_eq("rst_out_dec", 128'(bus.out_dec), 128'(0));
        check_eq("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
        sb.delete();
        mcnt = 0;
    endtask

    initial begin
        exp_t mul_e;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
        bus.in_pc = '0; bus.out_ready = 1'b0;

        do_reset();

        // addi, beq, lw through an empty FIFO (one-cycle latency)
        step(1, I_ADDI, 32'h1000, 1, 0, addi_exp(32'h1000));
        step(1, I_BEQ, 32'h1004, 1, 0,
             mk(CU_BRANCH, ALU_SUB, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29, 32'h1004, 0, 0));
        step(1, I_LW, 32'h1008, 1, 0,
             mk(CU_LOAD, ALU_ADD, 1, 0, 1, 1, 0, 1, 32'd8, 5'd1, 5'd8, 5'd5, 32'h1008, 0, 0));
        idle(1);

        // mul under either build, then the all-zero word
`ifdef RV32M_EN
        mul_e = mk(CU_REG, ALU_MUL, 1, 0, 0, 0, 0, 1, 32'd0, 5'd1, 5'd2, 5'd3, 32'h2000, 0, 0);
`else
        mul_e = illegal_exp(32'h2000);
`endif
        step(1, I_MUL, 32'h2000, 1, 0, mul_e);
        step(1, I_ZERO, 32'h2004, 1, 0, illegal_exp(32'h2004));
        idle(1);

        // Fill, hold while full, then push+pop across pointer wrap
        step(1, I_ADDI, 32'h100, 0, 0, addi_exp(32'h100));
        step(1, I_ADDI, 32'h104, 0, 0, addi_exp(32'h104));
        step(1, I_ADDI, 32'h108, 0, 0, addi_exp(32'h108));
        for (int i = 0; i < 4; i++)
            step(1, I_ADDI, 32'h10C + 32'(i * 4), 1, 0, addi_exp(32'h10C + 32'(i * 4)));
        idle(1); idle(1); idle(1);

        // Flush with two queued and a live input
        step(1, I_ADDI, 32'h200, 0, 0, addi_exp(32'h200));
        step(1, I_ADDI, 32'h204, 0, 0, addi_exp(32'h204));
        step(1, I_ADDI, 32'h208, 0, 1, addi_exp(32'h208));
        idle(1);
        step(1, I_LW, 32'h20C, 1, 0,
             mk(CU_LOAD, ALU_ADD, 1, 0, 1, 1, 0, 1, 32'd8, 5'd1, 5'd8, 5'd5, 32'h20C, 0, 0));
        idle(1);

        // Reset while non-empty, then resume
        step(1, I_ADDI, 32'h300, 0, 0, addi_exp(32'h300));
        step(1, I_ADDI, 32'h304, 0, 0, addi_exp(32'h304));
        do_reset();
        step(1, I_ADDI, 32'h400, 1, 0, addi_exp(32'h400));
        idle(1);

        // Random handshake traffic
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), I_ADDI, 32'h500 + 32'(i * 4),
                 $urandom_range(0, 3) != 0, 0, addi_exp(32'h500 + 32'(i * 4)));
        for (int i = 0; i < 4; i++) idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
